// File: rtl/mips_multicycle_control_if.sv
// Control-to-datapath bundle for the multicycle MIPS core: instruction fields and
// memory handshake in, mux selects / write enables / status flags out.
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_write_cond;
   logic       ir_write;
   logic       reg_write;
   logic       mem_read;
   logic       mem_write;
   logic       i_or_d;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctrl;
   logic [1:0] pc_source;
   logic       instr_done;
   logic       check_o;
   logic       illegal_o;
   logic       mem_err;

   modport master (
      input  opcode, funct, mem_ready,
      output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
             i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
             pc_source, instr_done, check_o, illegal_o, mem_err
   );

   modport slave (
      output opcode, funct, mem_ready,
      input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
             i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctrl,
             pc_source, instr_done, check_o, illegal_o, mem_err
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath, with a watchdog that traps
// memory accesses whose ready never arrives.
module mips_multicycle_control #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   mips_multicycle_control_if.master ctrl
);
   localparam int CntW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
   localparam logic [CntW-1:0] CntLimit = CntW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpAddiu = 6'b001001;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpCheck = 6'b111111;

   typedef enum logic [3:0] {
      StReset, StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite,
      StExecute, StAluWb, StAddiEx, StAddiWb, StBranch, StJump, StCheck,
      StIllegal, StError
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] waitCnt_q, waitCnt_d;
   logic            waitExpired;
   logic            memState;
   logic            functOk;
   logic [2:0]      functAlu;

   always_comb begin
      functAlu = 3'b010;
      functOk  = 1'b1;
      case (ctrl.funct)
         6'b100000: functAlu = 3'b010;
         6'b100010: functAlu = 3'b110;
         6'b100100: functAlu = 3'b000;
         6'b100101: functAlu = 3'b001;
         6'b101010: functAlu = 3'b111;
         default:   functOk  = 1'b0;
      endcase
   end

   // A disabled watchdog never expires, so the FSM waits on ready indefinitely.
   assign waitExpired = (MEM_WAIT_MAX != 0) && (waitCnt_q == CntLimit);

   always_comb begin
      state_d            = state_q;
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.i_or_d        = 1'b0;
      ctrl.reg_dst       = 1'b0;
      ctrl.mem_to_reg    = 1'b0;
      ctrl.alu_src_a     = 1'b0;
      ctrl.alu_src_b     = 2'b00;
      ctrl.alu_ctrl      = 3'b010;
      ctrl.pc_source     = 2'b00;
      ctrl.instr_done    = 1'b0;
      ctrl.check_o       = 1'b0;
      ctrl.illegal_o     = 1'b0;
      ctrl.mem_err       = 1'b0;
      case (state_q)
         StReset: begin
            ctrl.alu_ctrl = 3'b000;
            state_d       = StFetch;
         end
         StFetch: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = ctrl.mem_ready;
            ctrl.pc_write  = ctrl.mem_ready;
            if (ctrl.mem_ready)    state_d = StDecode;
            else if (waitExpired)  state_d = StError;
         end
         StDecode: begin
            ctrl.alu_src_b = 2'b11;
            case (ctrl.opcode)
               OpLw, OpSw: state_d = StMemAddr;
               OpRType:    state_d = StExecute;
               OpAddiu:    state_d = StAddiEx;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpCheck:    state_d = StCheck;
               default:    state_d = StIllegal;
            endcase
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_d        = (ctrl.opcode == OpLw) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
            if (ctrl.mem_ready)    state_d = StMemWb;
            else if (waitExpired)  state_d = StError;
         end
         StMemWb: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
         end
         StMemWrite: begin
            ctrl.mem_write  = 1'b1;
            ctrl.i_or_d     = 1'b1;
            ctrl.instr_done = ctrl.mem_ready;
            if (ctrl.mem_ready)    state_d = StFetch;
            else if (waitExpired)  state_d = StError;
         end
         StExecute: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_ctrl  = functAlu;
            state_d        = functOk ? StAluWb : StIllegal;
         end
         StAluWb: begin
            ctrl.reg_dst    = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            ctrl.alu_ctrl   = functAlu;
            state_d         = StFetch;
         end
         StAddiEx: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            state_d        = StAddiWb;
         end
         StAddiWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
         end
         StBranch: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_ctrl      = 3'b110;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
            ctrl.instr_done    = 1'b1;
            state_d            = StFetch;
         end
         StJump: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = 2'b10;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
         end
         StCheck: begin
            ctrl.check_o    = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
         end
         StIllegal: begin
            ctrl.illegal_o  = 1'b1;
            ctrl.instr_done = 1'b1;
            state_d         = StFetch;
         end
         StError: begin
            ctrl.alu_ctrl = 3'b000;
            ctrl.mem_err  = 1'b1;
         end
         default: state_d = StReset;
      endcase

      // Counter only advances while stalled in one memory state; any transition clears it.
      memState  = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
      waitCnt_d = '0;
      if ((MEM_WAIT_MAX != 0) && memState && !ctrl.mem_ready && (state_d == state_q))
         waitCnt_d = waitCnt_q + CntW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StReset;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for the multicycle MIPS control FSM: table of per-cycle vectors,
// expected outputs queued on drive and popped at the sampling edge.
module tb_mips_multicycle_control;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mips_multicycle_control_if ctrlIf();

   mips_multicycle_control #(.MEM_WAIT_MAX(15)) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (ctrlIf.master)
   );

   localparam logic [5:0] OpR   = 6'b000000;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpSw  = 6'b101011;
   localparam logic [5:0] OpAdi = 6'b001001;
   localparam logic [5:0] OpBeq = 6'b000100;
   localparam logic [5:0] OpJ   = 6'b000010;
   localparam logic [5:0] OpChk = 6'b111111;
   localparam logic [5:0] OpBad = 6'b000011;

   typedef enum {
      TbReset, TbFetch, TbDecode, TbMemAddr, TbMemRead, TbMemWb, TbMemWrite,
      TbExecute, TbAluWb, TbAddiEx, TbAddiWb, TbBranch, TbJump, TbCheck,
      TbIllegal, TbError
   } tbState_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       check_o;
      logic       illegal_o;
      logic       mem_err;
   } ctrlOut_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       rdy;
      tbState_e   st;
   } vec_t;

   typedef struct {
      ctrlOut_t val;
      string    tag;
   } sbItem_t;

   vec_t    vecs[$];
   sbItem_t expQ[$];
   int      checkCount = 0;
   int      passCount = 0;
   int      doneSeen = 0;
   int      doneExp = 0;

   // Expected outputs per spec state; the bench decodes funct independently.
   function automatic ctrlOut_t expOut(tbState_e st, logic rdy, logic [5:0] fn);
      ctrlOut_t   e;
      logic [2:0] fnAlu;
      e = '0;
      e.alu_ctrl = 3'b010;
      case (fn)
         6'b100010: fnAlu = 3'b110;
         6'b100100: fnAlu = 3'b000;
         6'b100101: fnAlu = 3'b001;
         6'b101010: fnAlu = 3'b111;
         default:   fnAlu = 3'b010;
      endcase
      case (st)
         TbReset:    e.alu_ctrl = 3'b000;
         TbFetch:    begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
         TbDecode:   e.alu_src_b = 2'b11;
         TbMemAddr:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         TbMemRead:  begin e.mem_read = 1; e.i_or_d = 1; end
         TbMemWb:    begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
         TbMemWrite: begin e.mem_write = 1; e.i_or_d = 1; e.instr_done = rdy; end
         TbExecute:  begin e.alu_src_a = 1; e.alu_ctrl = fnAlu; end
         TbAluWb:    begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; e.alu_ctrl = fnAlu; end
         TbAddiEx:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         TbAddiWb:   begin e.reg_write = 1; e.instr_done = 1; end
         TbBranch:   begin e.alu_src_a = 1; e.alu_ctrl = 3'b110; e.pc_write_cond = 1;
                           e.pc_source = 2'b01; e.instr_done = 1; end
         TbJump:     begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_done = 1; end
         TbCheck:    begin e.check_o = 1; e.instr_done = 1; end
         TbIllegal:  begin e.illegal_o = 1; e.instr_done = 1; end
         TbError:    begin e.alu_ctrl = 3'b000; e.mem_err = 1; end
         default:    e = '0;
      endcase
      return e;
   endfunction

   function automatic ctrlOut_t sampleOut();
      ctrlOut_t s;
      s.pc_write      = ctrlIf.pc_write;
      s.pc_write_cond = ctrlIf.pc_write_cond;
      s.ir_write      = ctrlIf.ir_write;
      s.reg_write     = ctrlIf.reg_write;
      s.mem_read      = ctrlIf.mem_read;
      s.mem_write     = ctrlIf.mem_write;
      s.i_or_d        = ctrlIf.i_or_d;
      s.reg_dst       = ctrlIf.reg_dst;
      s.mem_to_reg    = ctrlIf.mem_to_reg;
      s.alu_src_a     = ctrlIf.alu_src_a;
      s.alu_src_b     = ctrlIf.alu_src_b;
      s.alu_ctrl      = ctrlIf.alu_ctrl;
      s.pc_source     = ctrlIf.pc_source;
      s.instr_done    = ctrlIf.instr_done;
      s.check_o       = ctrlIf.check_o;
      s.illegal_o     = ctrlIf.illegal_o;
      s.mem_err       = ctrlIf.mem_err;
      return s;
   endfunction

   function automatic vec_t mkVec(logic [5:0] op, logic [5:0] fn, logic rdy, tbState_e st);
      vec_t v;
      v.op = op; v.fn = fn; v.rdy = rdy; v.st = st;
      return v;
   endfunction

   task automatic addVec(input logic [5:0] op, input logic [5:0] fn, input logic rdy, input tbState_e st);
      vecs.push_back(mkVec(op, fn, rdy, st));
   endtask

   task automatic expectState(input tbState_e st, input logic rdy, input logic [5:0] fn, input string tag);
      sbItem_t s;
      s.val = expOut(st, rdy, fn);
      s.tag = tag;
      expQ.push_back(s);
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      ctrlIf.opcode    = v.op;
      ctrlIf.funct     = v.fn;
      ctrlIf.mem_ready = v.rdy;
      expectState(v.st, v.rdy, v.fn, tag);
   endtask

   task automatic checkOutput();
      sbItem_t  s;
      ctrlOut_t got;
      checkCount++;
      if (expQ.size() == 0) begin
         $display("[TB] FAIL scoreboard: got empty queue, required one pending entry");
         return;
      end
      s   = expQ.pop_front();
      got = sampleOut();
      if (s.val.instr_done) doneExp++;
      if (got !== s.val)
         $display("[TB] FAIL %s: got %h, required %h", s.tag, got, s.val);
      else
         passCount++;
   endtask

   task automatic runRow(input vec_t v, input string tag);
      applyStimulus(v, tag);
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   // Reset is raised between edges so the async clear is checked before any clock.
   task automatic pulseReset(input string tag);
      reset = 1'b1;
      #1;
      expectState(TbReset, 1'b0, 6'd0, {tag, "Async"});
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b0;
      expectState(TbReset, 1'b0, 6'd0, {tag, "Hold"});
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk)
      if (ctrlIf.instr_done === 1'b1) doneSeen++;

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got no finish by 100000, required finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      logic [5:0] rFuncts[5];
      rFuncts = '{6'b100010, 6'b101010, 6'b100000, 6'b100100, 6'b100101};

      ctrlIf.opcode    = 6'd0;
      ctrlIf.funct     = 6'd0;
      ctrlIf.mem_ready = 1'b0;
      #1 reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      expectState(TbReset, 1'b0, 6'd0, "resetHeld");
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b0;
      expectState(TbReset, 1'b0, 6'd0, "resetReleased");
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;

      addVec(OpLw, 0, 1, TbFetch); addVec(OpLw, 0, 1, TbDecode); addVec(OpLw, 0, 1, TbMemAddr);
      addVec(OpLw, 0, 1, TbMemRead); addVec(OpLw, 0, 1, TbMemWb);
      foreach (rFuncts[k]) begin
         addVec(OpR, rFuncts[k], 1, TbFetch); addVec(OpR, rFuncts[k], 1, TbDecode);
         addVec(OpR, rFuncts[k], 1, TbExecute); addVec(OpR, rFuncts[k], 1, TbAluWb);
      end
      addVec(OpSw, 0, 1, TbFetch); addVec(OpSw, 0, 1, TbDecode); addVec(OpSw, 0, 1, TbMemAddr);
      for (int i = 0; i < 3; i++) addVec(OpSw, 0, 0, TbMemWrite);
      addVec(OpSw, 0, 1, TbMemWrite);
      addVec(OpBeq, 0, 1, TbFetch); addVec(OpBeq, 0, 1, TbDecode); addVec(OpBeq, 0, 1, TbBranch);
      addVec(OpJ, 0, 1, TbFetch); addVec(OpJ, 0, 1, TbDecode); addVec(OpJ, 0, 1, TbJump);
      addVec(OpAdi, 0, 1, TbFetch); addVec(OpAdi, 0, 0, TbDecode); addVec(OpAdi, 0, 0, TbAddiEx);
      addVec(OpAdi, 0, 0, TbAddiWb);
      addVec(OpChk, 0, 1, TbFetch); addVec(OpChk, 0, 1, TbDecode); addVec(OpChk, 0, 1, TbCheck);
      addVec(OpBad, 0, 1, TbFetch); addVec(OpBad, 0, 1, TbDecode); addVec(OpBad, 0, 1, TbIllegal);
      addVec(OpR, 0, 1, TbFetch); addVec(OpR, 0, 1, TbDecode); addVec(OpR, 0, 1, TbExecute);
      addVec(OpR, 0, 1, TbIllegal);
      addVec(OpLw, 0, 0, TbFetch); addVec(OpLw, 0, 0, TbFetch); addVec(OpLw, 0, 1, TbFetch);
      addVec(OpLw, 0, 1, TbDecode); addVec(OpLw, 0, 1, TbMemAddr);
      addVec(OpLw, 0, 0, TbMemRead); addVec(OpLw, 0, 0, TbMemRead); addVec(OpLw, 0, 1, TbMemRead);
      addVec(OpLw, 0, 1, TbMemWb);
      for (int i = 0; i < 14; i++) addVec(OpChk, 0, 0, TbFetch);
      addVec(OpChk, 0, 1, TbFetch); addVec(OpChk, 0, 1, TbDecode); addVec(OpChk, 0, 1, TbCheck);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t     v;
         tbState_e s;
         v = vecs[i];
         s = v.st;
         runRow(v, $sformatf("row%0d_%s", i, s.name()));
      end

      runRow(mkVec(OpLw, 0, 1, TbFetch), "midFetch");
      runRow(mkVec(OpLw, 0, 1, TbDecode), "midDecode");
      runRow(mkVec(OpLw, 0, 1, TbMemAddr), "midMemAddr");
      applyStimulus(mkVec(OpLw, 0, 0, TbMemRead), "midMemRead");
      #2;
      checkOutput();
      pulseReset("midReset");

      for (int i = 0; i < 15; i++) runRow(mkVec(OpChk, 0, 0, TbFetch), $sformatf("wdFetch%0d", i));
      for (int i = 0; i < 3; i++) runRow(mkVec(OpChk, 0, 1, TbError), $sformatf("wdError%0d", i));
      pulseReset("errReset");
      runRow(mkVec(OpChk, 0, 1, TbFetch), "recoverFetch");
      runRow(mkVec(OpChk, 0, 1, TbDecode), "recoverDecode");
      runRow(mkVec(OpChk, 0, 1, TbCheck), "recoverCheck");

      checkCount++;
      if (doneSeen != doneExp)
         $display("[TB] FAIL instrDoneCount: got %0d, required %0d", doneSeen, doneExp);
      else
         passCount++;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the MIPS core: a Moore-style FSM that sequences the shared datapath (single memory port, ALU, register file, PC) through fetch, decode and per-opcode execute phases. It decodes the opcode and funct fields of the instruction register and drives all datapath mux selects, write enables and the ALU operation code. It also handles variable-latency memory through a ready handshake with a watchdog, and flags illegal opcodes and the testbench `check` opcode.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum consecutive memory wait cycles before a fatal timeout; 0 disables the watchdog.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state RESET.
- `opcode`  in  6  instruction bits [31:26] from the instruction register.
- `funct`  in  6  instruction bits [5:0] from the instruction register.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`  out  1 each  write enables.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `reg_dst`  out  1  destination register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU A operand select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B operand select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `alu_ctrl`  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pc_source`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `check_o`, `illegal_o`  out  1 each  one-cycle event flags.
- `mem_err`  out  1  sticky watchdog timeout flag.

## Operation
- Outputs default to 0 in every state unless listed below.
- `alu_ctrl` defaults to 010 (add).
- RESET: all outputs 0. Next state is FETCH.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - When `mem_ready`=1, go to DECODE; otherwise stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11. Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 000000 (R-type) → EXECUTE.
  - 001001 (addiu) → ADDI_EX.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 111111 (check) → CHECK.
  - any other opcode → ILLEGAL.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: `mem_read`=1, `i_or_d`=1. Go to MEM_WB on `mem_ready`.
- MEM_WB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Go to FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1, `instr_done`=`mem_ready`. Go to FETCH on `mem_ready`.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00. `alu_ctrl` comes from funct:
  - 100000 → 010 (add), 100010 → 110 (sub), 100100 → 000 (and), 100101 → 001 (or), 101010 → 111 (slt).
  - Supported funct → ALU_WB; any other funct → ILLEGAL.
- ALU_WB: `reg_dst`=1, `reg_write`=1, `instr_done`=1, `alu_ctrl` still decoded from funct. Go to FETCH.
- ADDI_EX: `alu_src_a`=1, `alu_src_b`=10. Go to ADDI_WB.
- ADDI_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1, `instr_done`=1. Go to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl`=110, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Go to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Go to FETCH.
- CHECK: `check_o`=1, `instr_done`=1. Go to FETCH.
- ILLEGAL: `illegal_o`=1, `instr_done`=1. Go to FETCH; the PC is already advanced.
- ERROR: `mem_err`=1; all other outputs 0. Exit only on `reset`.
- Memory watchdog (the memory states are FETCH, MEM_READ and MEM_WRITE):
  - The wait counter is cleared on entry to any memory state.
  - Each cycle in a memory state with `mem_ready`=0: if counter == `MEM_WAIT_MAX`−1, go to ERROR; else increment.
  - `mem_ready`=1 always takes priority over timeout in the same cycle.
  - Counter width is $clog2(`MEM_WAIT_MAX`+1).
  - With `MEM_WAIT_MAX`=0 the watchdog is disabled and the FSM waits indefinitely.

## Timing
- State is registered. Outputs are combinational from state, plus `mem_ready`/`funct` where stated; no output registers.
- Zero-wait cycle counts, FETCH through the last state inclusive:
  - lw 5 cycles.
  - sw, R-type, addiu 4 cycles.
  - beq, j, check, illegal 3 cycles.
- Each memory wait cycle adds 1 cycle.
- `reset` asserted mid-instruction: state goes to RESET immediately, all outputs drop to 0 asynchronously, `mem_err` clears. FETCH is entered on the first rising edge after deassertion.
- `instr_done` is asserted exactly once per instruction and never in RESET or ERROR.

## Test plan
- Reset, then lw with `mem_ready` tied high → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. `reg_write`=1 and `mem_to_reg`=1 in cycle 5; `instr_done` asserted once.
- R-type with funct 100010, then 101010 → `alu_ctrl`=110, then 111, in EXECUTE and ALU_WB. `reg_dst`=1; 4 cycles each.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE → `mem_write` held high for 4 cycles; `instr_done` only in the ready cycle; 7 cycles total.
- beq, j, addiu, check in sequence:
  - beq: `pc_write_cond`=1 with `pc_source`=01 in cycle 3.
  - j: `pc_write`=1 with `pc_source`=10 in cycle 3.
  - addiu: 4 cycles.
  - check: `check_o` pulses for exactly 1 cycle.
- Opcode 000011, and R-type with funct 000000 → `illegal_o` pulse, then return to FETCH.
- `MEM_WAIT_MAX`=15 with `mem_ready` low in FETCH:
  - 15 low cycles → ERROR; `mem_err` sticky until `reset` pulse.
  - Ready high on the 15th cycle → DECODE, no error.
